// File: rtl/snake_pkg.sv
// snake_pkg: grid constants, coordinate types and placement FSM states shared by the snake game blocks.
package snake_pkg;
  localparam int GRID_W = 32;
  localparam int GRID_H = 24;
  typedef logic [4:0] coord_t;
  typedef struct packed {
    coord_t x;
    coord_t y;
  } cell_t;
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SCAN, COMMIT} state_t;
  localparam cell_t RESET_APPLE = {5'd8, 5'd16};
  function automatic logic in_grid(input cell_t c);
    return ({1'b0, c.x} < 6'(GRID_W)) && ({1'b0, c.y} < 6'(GRID_H));
  endfunction
  // Row-major step to the next cell; an off-grid start restarts the walk at the origin.
  function automatic cell_t walk_next(input cell_t c);
    logic wrap_x;
    cell_t n;
    wrap_x = {1'b0, c.x} >= 6'(GRID_W - 1);
    n.x = wrap_x ? '0 : c.x + coord_t'(1);
    n.y = !wrap_x ? c.y : ({1'b0, c.y} >= 6'(GRID_H - 1)) ? '0 : c.y + coord_t'(1);
    return in_grid(c) ? n : '0;
  endfunction
endpackage

// File: rtl/body_scan_unit.sv
// body_scan_unit: walks the snake body memory and compares each segment against a cell one cycle after its address.
module body_scan_unit
  import snake_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [IDX_W:0]   i_len,
  input  cell_t            i_cand,
  input  cell_t            i_seg,
  output logic [IDX_W-1:0] o_seg_idx,
  output logic             o_match,
  output logic             o_done
);
  logic [IDX_W:0] r_idx;
  logic           r_cmp;
  logic           w_more;
  assign w_more = r_idx < i_len;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
      r_cmp <= 1'b0;
    end else if (i_clr) begin
      r_idx <= '0;
      r_cmp <= 1'b0;
    end else begin
      r_idx <= (i_en && w_more) ? r_idx + (IDX_W + 1)'(1) : r_idx;
      r_cmp <= i_en && w_more;
    end
  end
  assign o_seg_idx = r_idx[IDX_W-1:0];
  assign o_match   = i_en && r_cmp && (i_seg == i_cand);
  assign o_done    = i_en && !w_more;
endmodule

// File: rtl/apple_place_ctrl.sv
// apple_place_ctrl: picks a free apple cell from random candidates, falling back to a cell walk after repeated conflicts.
module apple_place_ctrl
  import snake_pkg::*;
#(
  parameter  int MAX_LEN   = 64,
  parameter  int MAX_RETRY = 7,
  localparam int IDX_W     = $clog2(MAX_LEN),
  localparam int RW        = $clog2(MAX_RETRY + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             game_start,
  input  logic             apple_eaten,
  input  logic [4:0]       rnd_x,
  input  logic [4:0]       rnd_y,
  output logic             rnd_take,
  input  logic [IDX_W:0]   snake_len,
  output logic [IDX_W-1:0] seg_idx,
  input  logic [4:0]       seg_x,
  input  logic [4:0]       seg_y,
  output logic [4:0]       apple_x,
  output logic [4:0]       apple_y,
  output logic             apple_valid,
  output logic             busy,
  output logic             place_done,
  output logic             fallback
);
  state_t         r_state, w_next;
  logic [IDX_W:0] r_len_q;
  logic [RW-1:0]  r_retry;
  cell_t          r_cand, r_apple, w_rnd;
  logic           r_apple_valid, r_fallback;
  logic           w_start, w_conflict, w_retry_ok, w_rescan, w_match, w_done, w_scan_clr;
  assign w_rnd = {rnd_x, rnd_y};
  body_scan_unit #(.IDX_W(IDX_W)) u_scan (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_scan_clr),
    .i_en      (r_state == SCAN),
    .i_len     (r_len_q),
    .i_cand    (r_cand),
    .i_seg     ({seg_x, seg_y}),
    .o_seg_idx (seg_idx),
    .o_match   (w_match),
    .o_done    (w_done)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_start    = game_start || (r_state == IDLE && apple_eaten);
    w_retry_ok = r_retry < RW'(MAX_RETRY);
    w_conflict = (r_state == LOAD && !in_grid(w_rnd)) || (r_state == SCAN && w_match);
    w_rescan   = w_conflict && !w_retry_ok;
    w_scan_clr = r_state != SCAN || w_rescan || w_start;
    w_next     = w_start ? FETCH :
                 r_state == FETCH ? LOAD :
                 r_state == COMMIT ? IDLE :
                 w_conflict ? (w_retry_ok ? FETCH : SCAN) :
                 r_state == LOAD ? (r_len_q == '0 ? COMMIT : SCAN) :
                 (r_state == SCAN && w_done) ? COMMIT : r_state;
    rnd_take    = r_state == FETCH;
    busy        = r_state != IDLE;
    place_done  = r_state == COMMIT;
    apple_x     = r_apple.x;
    apple_y     = r_apple.y;
    apple_valid = r_apple_valid;
    fallback    = r_fallback;
  end
  // A restart wins over everything else in flight, including a pending commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len_q       <= '0;
      r_retry       <= '0;
      r_cand        <= '0;
      r_apple       <= RESET_APPLE;
      r_apple_valid <= 1'b0;
      r_fallback    <= 1'b0;
    end else if (w_start) begin
      r_len_q       <= snake_len;
      r_retry       <= '0;
      r_apple_valid <= 1'b0;
      r_fallback    <= 1'b0;
    end else begin
      if (r_state == LOAD) r_cand <= w_rescan ? walk_next(w_rnd) : w_rnd;
      else if (w_rescan) r_cand <= walk_next(r_cand);
      if (w_conflict && w_retry_ok) r_retry <= r_retry + RW'(1);
      if (w_rescan) r_fallback <= 1'b1;
      if (r_state == COMMIT) begin
        r_apple       <= r_cand;
        r_apple_valid <= 1'b1;
        r_fallback    <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_apple_place_ctrl.sv
// tb_apple_place_ctrl: directed and randomized apple placements checked against a cell-index reference model.
module tb_apple_place_ctrl;
  localparam int MAXR = 7;
  logic       clk = 1'b0;
  logic       rst, game_start, apple_eaten;
  logic [4:0] rnd_x, rnd_y, seg_x, seg_y, apple_x, apple_y;
  logic [6:0] snake_len;
  logic [5:0] seg_idx;
  logic       rnd_take, apple_valid, busy, place_done, fallback;
  logic [4:0] mem_x [64];
  logic [4:0] mem_y [64];
  logic [9:0] cand [8];
  int take_cnt = 0, base = 0, n_chk = 0, n_fail = 0;
  int e_x, e_y, e_takes, e_fb, e_cyc, last_got, last_takes;

  apple_place_ctrl dut (
    .clk(clk), .rst(rst), .game_start(game_start), .apple_eaten(apple_eaten),
    .rnd_x(rnd_x), .rnd_y(rnd_y), .rnd_take(rnd_take), .snake_len(snake_len),
    .seg_idx(seg_idx), .seg_x(seg_x), .seg_y(seg_y), .apple_x(apple_x),
    .apple_y(apple_y), .apple_valid(apple_valid), .busy(busy),
    .place_done(place_done), .fallback(fallback)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    seg_x <= mem_x[seg_idx];
    seg_y <= mem_y[seg_idx];
  end
  always @(posedge clk) begin
    if (rnd_take) begin
      {rnd_x, rnd_y} <= cand[3'(((take_cnt - base) < 7) ? (take_cnt - base) : 7)];
      take_cnt <= take_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int lin(input int x, input int y);
    return y * 32 + x;
  endfunction

  function automatic int hit(input int n, input int len);
    for (int i = 0; i < len; i++)
      if (lin(int'(mem_x[i]), int'(mem_y[i])) == n) return i;
    return -1;
  endfunction

  // Cycle cost: 2 per fetch, j+2 for a scan that hits body index j, len+1 for a clean scan, 1 for commit.
  task automatic predict(input int len);
    int x, y, n, j;
    e_cyc = 1; e_fb = 0; x = 0; y = 0;
    for (int t = 0; t <= MAXR; t++) begin
      x = int'(cand[t][9:5]); y = int'(cand[t][4:0]);
      e_takes = t + 1; e_cyc += 2;
      if (y < 24) begin
        j = hit(lin(x, y), len);
        if (j < 0) begin
          e_cyc += (len == 0) ? 0 : len + 1;
          e_x = x; e_y = y;
          return;
        end
        e_cyc += j + 2;
      end
    end
    e_fb = 1;
    n = (y < 24) ? (lin(x, y) + 1) % 768 : 0;
    while (1) begin
      j = hit(n, len);
      if (j < 0) break;
      e_cyc += j + 2;
      n = (n + 1) % 768;
    end
    e_cyc += len + 1;
    e_x = n % 32; e_y = n / 32;
  endtask

  task automatic place(input int mode, input int len, input bit noise);
    int got, first, fb, busy1;
    predict(len);
    snake_len = 7'(len); base = take_cnt;
    @(negedge clk);
    game_start = mode != 0; apple_eaten = mode != 1;
    got = 0; first = 0; fb = 0; busy1 = 0;
    for (int c = 1; c <= 20000; c++) begin
      @(negedge clk);
      game_start = 1'b0; apple_eaten = 1'b0;
      if (c == 1) begin
        snake_len = 7'($urandom_range(0, 64));
        busy1 = int'(busy);
      end
      if (rnd_take && first == 0) first = c;
      if (fallback) fb = 1;
      if (place_done) begin
        got = c;
        break;
      end
      if (c == 3 && noise) apple_eaten = 1'b1;
    end
    @(negedge clk);
    last_got = got; last_takes = take_cnt - base;
    chk("busy_c1", busy1, 1);
    chk("take_cycle", first, 1);
    chk("done_cycle", got, e_cyc);
    chk("apple_x", apple_x, e_x);
    chk("apple_y", apple_y, e_y);
    chk("apple_valid", apple_valid, 1);
    chk("busy_after", busy, 0);
    chk("done_after", place_done, 0);
    chk("fb_after", fallback, 0);
    chk("fb_seen", fb, e_fb);
    chk("takes", last_takes, e_takes);
  endtask

  task automatic set_cands(input logic [9:0] a, input logic [9:0] b);
    cand[0] = a;
    for (int i = 1; i < 8; i++) cand[i] = b;
  endtask

  task automatic rand_setup(output int len);
    int b, m, n, k, r, all;
    len = $urandom_range(0, 32); m = $urandom_range(0, 1); b = $urandom_range(0, 767);
    for (int i = 0; i < 64; i++) begin
      n = m ? (b + i) % 768 : $urandom_range(0, 767);
      mem_x[i] = 5'(n % 32); mem_y[i] = 5'(n / 32);
    end
    all = ($urandom_range(0, 3) == 0) ? 1 : 0;
    for (int t = 0; t < 8; t++) begin
      r = $urandom_range(0, 7);
      if (len > 0 && (all == 1 || (r >= 1 && r <= 3))) begin
        k = $urandom_range(0, len - 1);
        cand[t] = {mem_x[k], mem_y[k]};
      end else if (r == 0) cand[t] = {5'($urandom_range(0, 31)), 5'($urandom_range(24, 31))};
      else cand[t] = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 23))};
    end
  endtask

  initial begin
    int len;
    rst = 1'b1; game_start = 1'b0; apple_eaten = 1'b0; snake_len = '0;
    for (int i = 0; i < 64; i++) begin
      mem_x[i] = 5'(i % 32); mem_y[i] = 5'd10;
    end
    set_cands({5'd0, 5'd0}, {5'd0, 5'd0});
    repeat (3) @(negedge clk);
    chk("rst_apple_x", apple_x, 8);
    chk("rst_apple_y", apple_y, 16);
    chk("rst_valid", apple_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_take", rnd_take, 0);
    chk("rst_done", place_done, 0);
    chk("rst_fb", fallback, 0);
    chk("rst_seg_idx", seg_idx, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_busy", busy, 0);
    mem_x[0] = 5'd1; mem_y[0] = 5'd1;
    mem_x[1] = 5'd2; mem_y[1] = 5'd1;
    mem_x[2] = 5'd3; mem_y[2] = 5'd1;
    set_cands({5'd10, 5'd5}, {5'd0, 5'd0});
    place(0, 3, 0);
    chk("d1_latency", last_got, 7);
    set_cands({5'd2, 5'd1}, {5'd20, 5'd20});
    place(0, 3, 0);
    chk("d2_takes", last_takes, 2);
    mem_x[0] = 5'd31; mem_y[0] = 5'd23;
    set_cands({5'd31, 5'd23}, {5'd31, 5'd23});
    place(1, 3, 0);
    chk("d3_takes", last_takes, 8);
    chk("d3_apple", {apple_x, apple_y}, 0);
    set_cands({5'd4, 5'd30}, {5'd4, 5'd4});
    place(0, 3, 0);
    chk("d4_apple", {apple_x, apple_y}, {5'd4, 5'd4});
    set_cands({5'd7, 5'd7}, {5'd0, 5'd0});
    place(2, 0, 0);
    chk("d5_latency", last_got, 3);
    set_cands({5'd10, 5'd5}, {5'd0, 5'd0});
    snake_len = 7'd3;
    @(negedge clk);
    apple_eaten = 1'b1;
    @(negedge clk);
    apple_eaten = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_valid", apple_valid, 0);
    chk("mid_apple_x", apple_x, 8);
    chk("mid_apple_y", apple_y, 16);
    chk("mid_done", place_done, 0);
    chk("mid_take", rnd_take, 0);
    chk("mid_seg_idx", seg_idx, 0);
    @(negedge clk);
    rst = 1'b0;
    place(1, 3, 0);
    repeat (40) begin
      rand_setup(len);
      place($urandom_range(0, 2), len, 1'($urandom_range(0, 1)));
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
